apb_master: RTL

- APB requester that sits directly upstream of the APB slave and drives its PSELx/PENABLE/PWRITE/PADDR/PWDATA bus.
- Accepts one command at a time from a local valid/ready command port.
- Sequences the APB SETUP/ACCESS phases, waits on PREADY, and returns read data or write completion on a response port that the consumer can backpressure.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_timeout_ctr.sv | 26 ++
 rtl/apb_master.sv | 133 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB constants and the requester state encoding, common to master and slave.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 4;
    localparam int APB_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter; expired pulses on the wait cycle that reaches the limit.
module apb_timeout_ctr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    // expired is qualified by inc so a PREADY=1 cycle at the limit never aborts
    assign expired = inc && (cnt == limit - W'(1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time, SETUP/ACCESS sequencing, backpressured response.
// Optional ACCESS timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    output apb_mst_state_e        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; a
    // producer holds valid and its payload stable until that edge.
    apb_mst_state_e        state, state_n;
    logic                  psel_n, penable_n, pwrite_n;
    logic [ADDR_WIDTH-1:0] paddr_n;
    logic [DATA_WIDTH-1:0] pwdata_n, rsp_rdata_n;
    logic                  rsp_valid_n, rsp_err_n;
    logic                  tmo_expired;

    assign cmd_ready = (state == IDLE) && !PRESET;
    assign dbg_state = state;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    apb_timeout_ctr #(.W(TMO_W)) u_tmo (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (state == SETUP),
        .inc     ((state == ACCESS) && !PREADY),
        .limit   (TMO_W'(TIMEOUT_CYCLES)),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        psel_n      = PSELx;
        penable_n   = PENABLE;
        pwrite_n    = PWRITE;
        paddr_n     = PADDR;
        pwdata_n    = PWDATA;
        rsp_valid_n = rsp_valid;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    pwrite_n = cmd_write;
                    paddr_n  = cmd_addr;
                    pwdata_n = cmd_wdata;
                    psel_n   = 1'b1;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_n = PWRITE ? '0 : PRDATA;
                    rsp_err_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    state_n     = RESP;
                end else if (tmo_expired) begin
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b1;
                    rsp_valid_n = 1'b1;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    state_n     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            PSELx     <= psel_n;
            PENABLE   <= penable_n;
            PWRITE    <= pwrite_n;
            PADDR     <= paddr_n;
            PWDATA    <= pwdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

endmodule
